// File: rtl/mini_core.sv
// mini_core: single-cycle 8-bit CPU with a 32x8 instruction memory and A/B/O registers.
// One instruction retires per clk edge; no stalls, no handshakes, no backpressure.

module mini_core_imem (
    input  logic       clk,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdat,
    input  logic [4:0] raddr,
    output logic [7:0] rdat
);
    // Contents are loaded from outside through the hierarchy and never reset.
    reg [7:0] imem [0:31];

    always_ff @(posedge clk) begin
        if (we) begin
            imem[waddr] <= wdat;
        end
    end

    assign rdat = imem[raddr];
endmodule

module mini_core (
    input  logic clk,
    input  logic resetn
);
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_LDB  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_MVAB = 3'b100;
    localparam logic [2:0] OP_MVBO = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JC   = 3'b111;

    logic [4:0] pc_q, pc_d;
    logic       c_q, c_d;
    logic [7:0] regA, regA_d;
    logic [7:0] regB, regB_d;
    logic [7:0] regO, regO_d;
    logic [7:0] instr;
    logic [2:0] opcode;
    logic [4:0] imm5;

    // The core has no store path, so the memory write port stays idle.
    mini_core_imem imem_inst (
        .clk   (clk),
        .we    (1'b0),
        .waddr (5'd0),
        .wdat  (8'd0),
        .raddr (pc_q),
        .rdat  (instr)
    );

    assign opcode = instr[7:5];
    assign imm5   = instr[4:0];

    always_comb begin
        pc_d   = pc_q + 5'd1;
        c_d    = c_q;
        regA_d = regA;
        regB_d = regB;
        regO_d = regO;
        case (opcode)
            OP_NOP:  ;
            OP_LDA:  regA_d = {3'b000, imm5};
            OP_LDB:  regB_d = {3'b000, imm5};
            OP_ADD:  {c_d, regO_d} = {1'b0, regA} + {1'b0, regB};
            OP_MVAB: regA_d = regB;
            OP_MVBO: regB_d = regO;
            OP_JMP:  pc_d = imm5;
            OP_JC:   if (c_q) pc_d = imm5;
            default: ;
        endcase
    end

    // resetn is active-high despite its name.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            pc_q <= 5'd0;
            c_q  <= 1'b0;
            regA <= 8'd0;
            regB <= 8'd0;
            regO <= 8'd0;
        end else begin
            pc_q <= pc_d;
            c_q  <= c_d;
            regA <= regA_d;
            regB <= regB_d;
            regO <= regO_d;
        end
    end
endmodule

// File: tb/tb_mini_core.sv
// Directed bench for mini_core: loads programs through the imem hierarchy and
// checks register and pc state against hand-computed values.

module tb_mini_core;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LDA  = 3'b001;
    localparam logic [2:0] LDB  = 3'b010;
    localparam logic [2:0] ADD  = 3'b011;
    localparam logic [2:0] MVAB = 3'b100;
    localparam logic [2:0] MVBO = 3'b101;
    localparam logic [2:0] JMP  = 3'b110;
    localparam logic [2:0] JC   = 3'b111;

    mini_core dut (
        .clk    (clk),
        .resetn (resetn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] imm);
        return {op, imm};
    endfunction

    task automatic load_nops();
        for (int i = 0; i < 32; i++) dut.imem_inst.imem[i] = 8'h00;
    endtask

    task automatic put(input int addr, input logic [7:0] v);
        dut.imem_inst.imem[addr] = v;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b0;
    endtask

    int fib_exp [13] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b1;

        // LDA 5, LDB 7, ADD, then halt at 3
        load_nops();
        put(0, ins(LDA, 5'd5));
        put(1, ins(LDB, 5'd7));
        put(2, ins(ADD, 5'd0));
        put(3, ins(JMP, 5'd3));
        step(2);
        check("rst_a", dut.regA, 0);
        check("rst_b", dut.regB, 0);
        check("rst_o", dut.regO, 0);
        check("rst_pc", dut.pc_q, 0);
        check("rst_c", dut.c_q, 0);

        release_reset();
        step(3);
        check("add_o", dut.regO, 12);
        check("add_c", dut.c_q, 0);
        check("add_a", dut.regA, 5);
        check("add_b", dut.regB, 7);
        step(3);
        check("halt_pc", dut.pc_q, 3);
        check("halt_o", dut.regO, 12);
        check("halt_a", dut.regA, 5);

        // Asynchronous reset between edges
        resetn = 1'b1;
        #2;
        check("async_a", dut.regA, 0);
        check("async_b", dut.regB, 0);
        check("async_o", dut.regO, 0);
        check("async_pc", dut.pc_q, 0);
        check("imem_kept", dut.imem_inst.imem[0], ins(LDA, 5'd5));

        // JMP 4 from address 0
        load_nops();
        put(0, ins(JMP, 5'd4));
        put(4, ins(JMP, 5'd4));
        release_reset();
        step(1);
        check("jmp_pc", dut.pc_q, 4);

        // Overflow chain with JC fall-through and taken
        resetn = 1'b1;
        load_nops();
        put(0, ins(LDA, 5'd31));
        put(1, ins(LDB, 5'd31));
        put(2, ins(ADD, 5'd0));
        put(3, ins(JC, 5'd9));
        put(4, ins(MVBO, 5'd0));
        put(5, ins(MVAB, 5'd0));
        put(6, ins(JMP, 5'd2));
        put(9, ins(JMP, 5'd9));
        release_reset();
        step(3);
        check("ovf_o1", dut.regO, 62);
        check("ovf_c1", dut.c_q, 0);
        step(1);
        check("jc_fall_pc", dut.pc_q, 4);
        step(9);
        check("ovf_o3", dut.regO, 248);
        check("ovf_c3", dut.c_q, 0);
        step(5);
        check("ovf_wrap_o", dut.regO, 240);
        check("ovf_wrap_c", dut.c_q, 1);
        step(1);
        check("jc_taken_pc", dut.pc_q, 9);
        step(3);
        check("ovf_hold_pc", dut.pc_q, 9);
        check("ovf_hold_a", dut.regA, 248);
        check("ovf_hold_b", dut.regB, 248);
        check("ovf_hold_o", dut.regO, 240);
        check("ovf_hold_c", dut.c_q, 1);

        // Fibonacci reference program
        resetn = 1'b1;
        load_nops();
        put(0, ins(LDA, 5'd0));
        put(1, ins(LDB, 5'd1));
        put(2, ins(ADD, 5'd0));
        put(3, ins(MVAB, 5'd0));
        put(4, ins(MVBO, 5'd0));
        put(5, ins(JC, 5'd7));
        put(6, ins(JMP, 5'd2));
        put(7, ins(JMP, 5'd7));
        release_reset();
        step(3);
        for (int k = 0; k < 13; k++) begin
            check($sformatf("fib_o%0d", k), dut.regO, fib_exp[k]);
            check($sformatf("fib_c%0d", k), dut.c_q, (k == 12) ? 1 : 0);
            if (k < 12) step(5);
        end
        step(3);
        check("fib_jc_pc", dut.pc_q, 7);
        step(3);
        check("fib_halt_pc", dut.pc_q, 7);
        check("fib_halt_a", dut.regA, 233);
        check("fib_halt_b", dut.regB, 121);
        check("fib_halt_o", dut.regO, 121);

        // Swap the program for all NOPs while running: pc wraps, state holds
        load_nops();
        step(24);
        check("wrap_pc31", dut.pc_q, 31);
        step(1);
        check("wrap_pc0", dut.pc_q, 0);
        check("wrap_a", dut.regA, 233);
        check("wrap_b", dut.regB, 121);
        check("wrap_o", dut.regO, 121);
        check("wrap_c", dut.c_q, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
